ifm_row_loader: RTL and testbench

//  Services the controller's IFM row-load requests (req_load/req_row -> req_done). For each request it

---
 rtl/ifm_row_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_ifm_row_loader.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_row_loader.sv
// ----------------------------------------------------------------------------
// ifm_row_loader
//   Services row-load requests from the CNN controller. For each requested IFM
//   row it computes the row's DRAM byte address, splits the row into read
//   bursts of at most MAX_BURST beats on a single memory read port (exactly one
//   burst outstanding), and writes the returned beats into the row-buffer ring
//   slot row % IFM_BUF_CNT at word index chn*width + col (the beat index).
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   q_start              latch q_width/q_channel/q_base_addr (IDLE only),
//                        also clears o_req_overrun
//   q_width, q_channel   IFM width in pixels, tiled channel count
//   q_base_addr          byte address of row 0, col 0, chn 0
//   i_req_load/i_req_row 1-cycle row load request and its row number
//   o_req_done           1-cycle pulse coincident with the row's final write
//   o_busy               high whenever the loader is not idle
//   o_req_overrun        sticky: a load request arrived while busy
//   o_rd_req_*           memory read request channel (valid/ready, addr, len)
//   i_rd_data_valid/data returned read beats, in order, no backpressure
//   o_buf_we/sel/addr/wdata  registered row-buffer write port
// ----------------------------------------------------------------------------
module ifm_row_loader #(
    parameter int unsigned W_SIZE      = 9,
    parameter int unsigned W_CHANNEL   = 9,
    parameter int unsigned IFM_BUF_CNT = 4,
    parameter int unsigned W_IFM_BUF   = 2,
    parameter int unsigned W_ADDR      = 32,
    parameter int unsigned W_DATA      = 64,
    parameter int unsigned W_BUF_ADDR  = 12,
    parameter int unsigned MAX_BURST   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   q_start,
    input  logic [W_SIZE-1:0]      q_width,
    input  logic [W_CHANNEL-1:0]   q_channel,
    input  logic [W_ADDR-1:0]      q_base_addr,
    input  logic                   i_req_load,
    input  logic [W_SIZE-1:0]      i_req_row,
    output logic                   o_req_done,
    output logic                   o_busy,
    output logic                   o_req_overrun,
    output logic                   o_rd_req_valid,
    input  logic                   i_rd_req_ready,
    output logic [W_ADDR-1:0]      o_rd_req_addr,
    output logic [4:0]             o_rd_req_len,
    input  logic                   i_rd_data_valid,
    input  logic [W_DATA-1:0]      i_rd_data,
    output logic                   o_buf_we,
    output logic [W_IFM_BUF-1:0]   o_buf_sel,
    output logic [W_BUF_ADDR-1:0]  o_buf_addr,
    output logic [W_DATA-1:0]      o_buf_wdata
);

    localparam int unsigned W_BEATS    = W_SIZE + W_CHANNEL;
    localparam int unsigned BEAT_SHIFT = $clog2(W_DATA / 8);
    localparam int unsigned W_LEN      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // latched configuration
    logic [W_BEATS-1:0]    r_row_beats;
    logic [W_ADDR-1:0]     r_base;

    // per-row working state
    logic [W_SIZE-1:0]     r_row;
    logic [W_ADDR-1:0]     r_addr;
    logic [W_BEATS-1:0]    r_remaining;
    logic [W_LEN-1:0]      r_burst_left;
    logic [W_BUF_ADDR-1:0] r_beat_idx;
    logic                  r_overrun;

    // registered row-buffer write port
    logic                  r_buf_we;
    logic [W_IFM_BUF-1:0]  r_buf_sel;
    logic [W_BUF_ADDR-1:0] r_buf_addr;
    logic [W_DATA-1:0]     r_buf_wdata;

    logic [W_LEN-1:0]      w_len;
    logic [W_ADDR-1:0]     w_row_bytes;
    logic [W_ADDR-1:0]     w_row_addr;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_burst_end;

    assign w_accept    = (r_state == S_REQ) && i_rd_req_ready;
    assign w_beat      = (r_state == S_DATA) && i_rd_data_valid;
    assign w_burst_end = w_beat && (r_burst_left == W_LEN'(1));

    // r_remaining is already net of the outstanding burst, so zero at the
    // burst's last beat means the whole row has arrived.
    always_comb begin
        if (r_remaining > W_BEATS'(MAX_BURST)) begin
            w_len = W_LEN'(MAX_BURST);
        end else begin
            w_len = W_LEN'(r_remaining);
        end
    end

    assign w_row_bytes = W_ADDR'(r_row_beats) << BEAT_SHIFT;
    assign w_row_addr  = r_base + W_ADDR'(r_row) * w_row_bytes;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next         = r_state;
        o_busy         = 1'b1;
        o_req_done     = 1'b0;
        o_rd_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_req_load) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_row_beats == '0) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                o_rd_req_valid = 1'b1;
                if (i_rd_req_ready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_burst_end) begin
                    if (r_remaining == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_DONE: begin
                o_req_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration, overrun flag and row datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row_beats  <= '0;
            r_base       <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_burst_left <= '0;
            r_beat_idx   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (q_start) begin
                    r_row_beats <= W_BEATS'(q_width) * W_BEATS'(q_channel);
                    r_base      <= q_base_addr;
                    r_overrun   <= 1'b0;
                end
                if (i_req_load) begin
                    r_row <= i_req_row;
                end
            end else if (i_req_load) begin
                r_overrun <= 1'b1;
            end

            if (r_state == S_CALC) begin
                r_addr      <= w_row_addr;
                r_remaining <= r_row_beats;
                r_beat_idx  <= '0;
            end

            if (w_accept) begin
                r_addr       <= r_addr + (W_ADDR'(w_len) << BEAT_SHIFT);
                r_remaining  <= r_remaining - W_BEATS'(w_len);
                r_burst_left <= w_len;
            end

            if (w_beat) begin
                r_burst_left <= r_burst_left - W_LEN'(1);
                r_beat_idx   <= r_beat_idx + W_BUF_ADDR'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Row-buffer write port (one cycle after each accepted beat)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_we    <= 1'b0;
            r_buf_sel   <= '0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
        end else begin
            r_buf_we <= w_beat;
            if (w_beat) begin
                r_buf_sel   <= r_row[W_IFM_BUF-1:0];
                r_buf_addr  <= r_beat_idx;
                r_buf_wdata <= i_rd_data;
            end
        end
    end

    assign o_req_overrun = r_overrun;
    assign o_rd_req_addr = r_addr;
    assign o_rd_req_len  = w_len;
    assign o_buf_we      = r_buf_we;
    assign o_buf_sel     = r_buf_sel;
    assign o_buf_addr    = r_buf_addr;
    assign o_buf_wdata   = r_buf_wdata;

endmodule

// File: tb/tb_ifm_row_loader.sv
// ----------------------------------------------------------------------------
// tb_ifm_row_loader
//   Self-checking bench for ifm_row_loader. A table of row requests with
//   hand-computed row addresses drives the DUT; expected bursts and buffer
//   writes are queued when each request is issued and popped as the DUT
//   issues bursts / writes. A small memory responder returns beats whose data
//   encodes the byte address they came from. Hand-written sequences cover
//   overrun, back-pressure on the request channel and reset mid-row.
// ----------------------------------------------------------------------------
module tb_ifm_row_loader;

    logic        clk;
    logic        rstn;
    logic        q_start;
    logic [8:0]  q_width;
    logic [8:0]  q_channel;
    logic [31:0] q_base_addr;
    logic        i_req_load;
    logic [8:0]  i_req_row;
    logic        o_req_done;
    logic        o_busy;
    logic        o_req_overrun;
    logic        o_rd_req_valid;
    logic        i_rd_req_ready;
    logic [31:0] o_rd_req_addr;
    logic [4:0]  o_rd_req_len;
    logic        i_rd_data_valid;
    logic [63:0] i_rd_data;
    logic        o_buf_we;
    logic [1:0]  o_buf_sel;
    logic [11:0] o_buf_addr;
    logic [63:0] o_buf_wdata;

    ifm_row_loader #(
        .W_SIZE      (9),
        .W_CHANNEL   (9),
        .IFM_BUF_CNT (4),
        .W_IFM_BUF   (2),
        .W_ADDR      (32),
        .W_DATA      (64),
        .W_BUF_ADDR  (12),
        .MAX_BURST   (16)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .q_start         (q_start),
        .q_width         (q_width),
        .q_channel       (q_channel),
        .q_base_addr     (q_base_addr),
        .i_req_load      (i_req_load),
        .i_req_row       (i_req_row),
        .o_req_done      (o_req_done),
        .o_busy          (o_busy),
        .o_req_overrun   (o_req_overrun),
        .o_rd_req_valid  (o_rd_req_valid),
        .i_rd_req_ready  (i_rd_req_ready),
        .o_rd_req_addr   (o_rd_req_addr),
        .o_rd_req_len    (o_rd_req_len),
        .i_rd_data_valid (i_rd_data_valid),
        .i_rd_data       (i_rd_data),
        .o_buf_we        (o_buf_we),
        .o_buf_sel       (o_buf_sel),
        .o_buf_addr      (o_buf_addr),
        .o_buf_wdata     (o_buf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          w;
        int          c;
        int          row;
        logic [31:0] base;
        logic [31:0] addr0;   // hand-computed base + row*w*c*8 (mod 2^32)
        int          sel;
        int          delay;   // cycles i_rd_req_ready is held low per burst
        bit          cfg;     // pulse q_start before the request
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_wq[$];
    logic [31:0] exp_ba[$];
    logic [4:0]  exp_bl[$];

    int n_tests;
    int n_fail;
    int done_cnt;
    int wr_cnt;
    int rows_run;
    bit exp_we_at_done;
    bit prev_done;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: compare writes and done timing away from the edge.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_done = 1'b0;
        end else begin
            if (o_buf_we) begin
                wr_t e;
                wr_cnt++;
                if (exp_wq.size() == 0) begin
                    chk("unexpected_write", {63'd0, o_buf_we}, 64'd0);
                end else begin
                    e = exp_wq.pop_front();
                    chk("wr_sel", o_buf_sel, e.sel);
                    chk("wr_addr", o_buf_addr, e.addr);
                    chk("wr_data", o_buf_wdata, e.data);
                end
            end
            if (o_req_done) begin
                done_cnt++;
                chk("done_with_last_write", o_buf_we, exp_we_at_done);
                chk("done_after_all_writes", exp_wq.size(), 0);
                chk("busy_in_done", o_busy, 1);
            end
            if (prev_done) chk("busy_falls_after_done", o_busy, 0);
            prev_done = o_req_done;
        end
    end

    task automatic configure(input int w, input int c, input logic [31:0] base);
        q_width     = 9'(w);
        q_channel   = 9'(c);
        q_base_addr = base;
        q_start     = 1'b1;
        @(posedge clk); #1;
        q_start     = 1'b0;
    endtask

    // Issue one row request and act as memory until done (or budget expiry).
    task automatic run_row(input vec_t v, input int inject_beat);
        int          beats;
        int          rem;
        int          l;
        int          budget;
        int          beat_no;
        int          d0;
        logic [31:0] a;
        logic [31:0] ca;
        logic [4:0]  cl;
        wr_t         e;

        beats = v.w * v.c;
        for (int k = 0; k < beats; k++) begin
            e.sel  = 2'(v.sel);
            e.addr = 12'(k);
            e.data = mem_word(v.addr0 + 32'(k * 8));
            exp_wq.push_back(e);
        end
        rem = beats;
        a   = v.addr0;
        while (rem > 0) begin
            l = (rem > 16) ? 16 : rem;
            exp_ba.push_back(a);
            exp_bl.push_back(5'(l));
            a   = a + 32'(l * 8);
            rem = rem - l;
        end
        exp_we_at_done = (beats > 0);
        d0 = done_cnt;
        rows_run++;

        chk("idle_before_load", o_busy, 0);
        i_req_load = 1'b1;
        i_req_row  = 9'(v.row);
        @(posedge clk); #1;
        i_req_load = 1'b0;
        chk("busy_after_load", o_busy, 1);
        chk("req_valid_T+1", o_rd_req_valid, 0);
        @(posedge clk); #1;
        chk("req_valid_T+2", o_rd_req_valid, beats > 0);

        budget  = 0;
        beat_no = 0;
        while (done_cnt == d0 && budget < 400) begin
            if (o_rd_req_valid) begin
                ca = o_rd_req_addr;
                cl = o_rd_req_len;
                for (int j = 0; j < v.delay; j++) begin
                    @(posedge clk); #1;
                    budget++;
                    chk("hold_valid", o_rd_req_valid, 1);
                    chk("hold_addr", o_rd_req_addr, ca);
                    chk("hold_len", o_rd_req_len, cl);
                end
                i_rd_req_ready = 1'b1;
                @(posedge clk); #1;
                i_rd_req_ready = 1'b0;
                budget++;
                chk("no_duplicate_req", o_rd_req_valid, 0);
                if (exp_ba.size() == 0) begin
                    chk("unexpected_burst_len", cl, 0);
                end else begin
                    chk("burst_addr", ca, exp_ba.pop_front());
                    chk("burst_len", cl, exp_bl.pop_front());
                end
                for (int j = 0; j < int'(cl); j++) begin
                    i_rd_data_valid = 1'b1;
                    i_rd_data       = mem_word(ca + 32'(j * 8));
                    if (beat_no == inject_beat) begin
                        i_req_load = 1'b1;
                        i_req_row  = 9'd9;
                        q_start    = 1'b1;
                        q_width    = 9'd7;
                    end
                    @(posedge clk); #1;
                    budget++;
                    beat_no++;
                    i_req_load = 1'b0;
                    i_req_row  = 9'(v.row);
                    q_start    = 1'b0;
                    q_width    = 9'(v.w);
                end
                i_rd_data_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                budget++;
            end
        end
        chk("row_done_within_budget", done_cnt, d0 + 1);
        chk("all_bursts_issued", exp_ba.size(), 0);
        chk("all_writes_seen", exp_wq.size(), 0);
        exp_ba.delete();
        exp_bl.delete();
        exp_wq.delete();
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        int   w0;

        n_tests = 0; n_fail = 0; done_cnt = 0; wr_cnt = 0; rows_run = 0;
        exp_we_at_done = 1'b0; prev_done = 1'b0;
        rstn = 1'b0; q_start = 1'b0; q_width = '0; q_channel = '0; q_base_addr = '0;
        i_req_load = 1'b0; i_req_row = '0; i_rd_req_ready = 1'b0;
        i_rd_data_valid = 1'b0; i_rd_data = '0;

        //          w   c   row  base          addr0          sel dly cfg
        vecs[0] = '{4,  2,  0,   32'h0000_1000, 32'h0000_1000, 0, 0, 1};
        vecs[1] = '{4,  2,  3,   32'h0000_1000, 32'h0000_10C0, 3, 7, 0};
        vecs[2] = '{10, 2,  1,   32'h0000_1000, 32'h0000_10A0, 1, 0, 1};
        vecs[3] = '{4,  1,  5,   32'h0000_1000, 32'h0000_10A0, 1, 1, 1};
        vecs[4] = '{0,  3,  2,   32'h0000_1000, 32'h0000_0000, 2, 0, 1};
        vecs[5] = '{5,  7,  6,   32'hFFFF_FF00, 32'h0000_0590, 2, 2, 1};
        vecs[6] = '{3,  16, 511, 32'h0000_2000, 32'h0003_1E80, 3, 0, 1};
        vecs[7] = '{16, 1,  4,   32'h0000_0000, 32'h0000_0200, 0, 0, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_req_done, 0);
        chk("rst_overrun", o_req_overrun, 0);
        chk("rst_rd_valid", o_rd_req_valid, 0);
        chk("rst_rd_addr", o_rd_req_addr, 0);
        chk("rst_rd_len", o_rd_req_len, 0);
        chk("rst_buf_we", o_buf_we, 0);
        chk("rst_buf_sel", o_buf_sel, 0);
        chk("rst_buf_addr", o_buf_addr, 0);
        chk("rst_buf_wdata", o_buf_wdata, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven rows; vecs[1] reuses vecs[0]'s config and is issued
        // in the first idle cycle after vecs[0] finishes.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            if (v.cfg) configure(v.w, v.c, v.base);
            run_row(v, -1);
        end

        // Overrun: load request and config change during DATA are ignored.
        configure(4, 2, 32'h0000_1000);
        chk("overrun_clear_before", o_req_overrun, 0);
        v = '{4, 2, 1, 32'h0000_1000, 32'h0000_1040, 1, 0, 0};
        run_row(v, 2);
        chk("overrun_set", o_req_overrun, 1);
        @(posedge clk); #1;
        chk("overrun_sticky", o_req_overrun, 1);
        configure(4, 2, 32'h0000_1000);
        chk("overrun_cleared_by_start", o_req_overrun, 0);

        // Reset in the middle of a row's data phase.
        begin
            wr_t e;
            for (int k = 0; k < 3; k++) begin
                e.sel  = 2'd2;
                e.addr = 12'(k);
                e.data = mem_word(32'h0000_1080 + 32'(k * 8));
                exp_wq.push_back(e);
            end
            exp_we_at_done = 1'b1;
            i_req_load = 1'b1;
            i_req_row  = 9'd2;
            @(posedge clk); #1;
            i_req_load = 1'b0;
            @(posedge clk); #1;
            chk("rstmid_req_valid", o_rd_req_valid, 1);
            chk("rstmid_req_addr", o_rd_req_addr, 32'h0000_1080);
            i_rd_req_ready = 1'b1;
            @(posedge clk); #1;
            i_rd_req_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
                i_rd_data_valid = 1'b1;
                i_rd_data       = mem_word(32'h0000_1080 + 32'(j * 8));
                @(posedge clk); #1;
            end
            i_rd_data_valid = 1'b0;
            @(negedge clk); #1;
            chk("rstmid_writes_seen", exp_wq.size(), 0);
            chk("rstmid_busy_before", o_busy, 1);
            rstn = 1'b0;
            #1;
            chk("rstmid_busy", o_busy, 0);
            chk("rstmid_buf_we", o_buf_we, 0);
            chk("rstmid_buf_addr", o_buf_addr, 0);
            chk("rstmid_buf_wdata", o_buf_wdata, 0);
            chk("rstmid_rd_addr", o_rd_req_addr, 0);
            chk("rstmid_rd_valid", o_rd_req_valid, 0);
            exp_wq.delete();
            repeat (2) @(posedge clk);
            #1;
            rstn = 1'b1;
            @(posedge clk); #1;
            chk("rstmid_idle_after", o_busy, 0);
        end

        // Read beats arriving while idle must not write.
        w0 = wr_cnt;
        for (int j = 0; j < 3; j++) begin
            i_rd_data_valid = 1'b1;
            i_rd_data       = 64'hDEAD_BEEF_0000_0000 + 64'(j);
            @(posedge clk); #1;
        end
        i_rd_data_valid = 1'b0;
        @(posedge clk); #1;
        chk("no_write_when_idle", wr_cnt, w0);

        // Normal operation after reset (config was cleared, so latch again).
        configure(4, 2, 32'h0000_1000);
        v = '{4, 2, 6, 32'h0000_1000, 32'h0000_1180, 2, 0, 0};
        run_row(v, -1);

        chk("total_dones", done_cnt, rows_run);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
